// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: imem req/ack, IF/ID register, stall/flush/timeout handling
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0100_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        fetch_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        flush,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        fetch_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, DROP, FAULT} state_t;

    state_t        state, state_next;
    logic [31:0]   buffer, req_addr;
    logic [CW-1:0] wait_cnt;
    logic          load_buffer, latch_addr, if_write, counting;
    logic [31:0]   write_instr;

    assign fetch_fault = (state == FAULT);

    always_comb begin
        state_next  = state;
        fetch_stall = 1'b1;
        imem_req    = 1'b0;
        imem_addr   = 32'h0;
        load_buffer = 1'b0;
        latch_addr  = 1'b0;
        if_write    = 1'b0;
        write_instr = buffer;
        counting    = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (pc[1:0] != 2'b00) begin
                    state_next = FAULT;
                end else begin
                    imem_req  = 1'b1;
                    imem_addr = pc;
                    if (imem_ack) begin
                        if (flush) begin
                            fetch_stall = 1'b0;
                        end else if (id_stall) begin
                            load_buffer = 1'b1;
                            state_next  = HOLD;
                        end else begin
                            fetch_stall = 1'b0;
                            if_write    = 1'b1;
                            write_instr = imem_rdata;
                        end
                    end else if (flush) begin
                        // Request cannot be withdrawn: finish it in DROP while the PC moves on
                        fetch_stall = 1'b0;
                        latch_addr  = 1'b1;
                        state_next  = DROP;
                    end else begin
                        counting = 1'b1;
                        if (wait_cnt == WAIT_LIMIT) state_next = FAULT;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    fetch_stall = 1'b0;
                    state_next  = REQ;
                end else if (!id_stall) begin
                    fetch_stall = 1'b0;
                    if_write    = 1'b1;
                    state_next  = REQ;
                end
            end
            DROP: begin
                imem_req    = 1'b1;
                imem_addr   = req_addr;
                fetch_stall = !flush;
                if (imem_ack) begin
                    state_next = REQ;
                end else begin
                    counting = 1'b1;
                    if (wait_cnt == WAIT_LIMIT) state_next = FAULT;
                end
            end
            FAULT: ;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            buffer   <= 32'h0;
            req_addr <= 32'h0;
            wait_cnt <= '0;
            id_pc    <= RESET_PC;
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (load_buffer) buffer <= imem_rdata;
            if (latch_addr) req_addr <= pc;
            wait_cnt <= (counting && state_next == state) ? wait_cnt + 1'b1 : '0;
            if (flush && state != FAULT) begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
            end else if (!id_stall) begin
                if (if_write) begin
                    id_pc    <= pc;
                    id_instr <= write_instr;
                    id_valid <= 1'b1;
                end else begin
                    id_instr <= NOP_INSTR;
                    id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          TMO      = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = RESET_PC;
    logic        fetch_stall, imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] id_pc, id_instr;
    logic        id_valid, fetch_fault;

    fetch_unit dut (
        .clock(clock), .reset(reset), .pc(pc), .fetch_stall(fetch_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .id_stall(id_stall), .flush(flush),
        .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .fetch_fault(fetch_fault)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    bit          drv_flush = 0, drv_stall = 0;
    logic [31:0] drv_target = 32'h0, target = 32'h0;
    int          mem_lat = 0;
    bit          mem_busy = 0;
    int          mem_cnt = 0;
    bit          prev_flush = 0, prev_stall = 1;
    logic [31:0] prev_target = 32'h0;

    bit          m_started, m_fault, m_holding, m_dropping, m_valid, was_fault;
    logic [31:0] m_word, m_drop_addr, m_pc, m_instr;
    int          m_wait;
    bit          e_req, e_stall, wr;
    logic [31:0] e_addr, wr_instr;
    int          req_cycles;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: PC counter behaviour, decode/flush knobs, then a memory that may ack same-cycle
    task automatic tick(input bit rst);
        @(posedge clock);
        #1;
        reset = rst;
        if (rst) begin
            pc       = RESET_PC;
            flush    = 1'b0;
            id_stall = 1'b0;
        end else begin
            if (prev_flush) pc = prev_target;
            else if (!prev_stall) pc = pc + 32'd4;
            flush    = drv_flush;
            id_stall = drv_stall;
            target   = drv_target;
        end
        #1;
        if (!rst && imem_req === 1'b1) begin
            if (!mem_busy) begin
                mem_busy = 1;
                if (mem_lat >= 0) mem_cnt = mem_lat;
                else mem_cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 3));
            end
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = word(imem_addr);
                mem_busy   = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_cnt--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            mem_busy   = 0;
        end
    endtask

    task automatic rst_cycle();
        drv_flush = 0;
        drv_stall = 0;
        tick(1);
    endtask

    // Reference: a fetch is either not yet started, requesting, holding a word for decode, draining a flushed request, or faulted
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                m_started = 0; m_fault = 0; m_holding = 0; m_dropping = 0; m_wait = 0;
                m_word = 0; m_drop_addr = 0; m_pc = RESET_PC; m_instr = NOP; m_valid = 0;
                prev_flush = 0; prev_stall = 1;
            end else begin
                e_req = 0; e_addr = 32'h0; e_stall = 1; wr = 0; wr_instr = 32'h0;
                if (!m_started || m_fault) begin
                end else if (m_holding) begin
                    e_stall = !(flush || !id_stall);
                end else if (m_dropping) begin
                    e_req = 1; e_addr = m_drop_addr; e_stall = !flush;
                end else if (pc[1:0] == 2'b00) begin
                    e_req = 1; e_addr = pc;
                    e_stall = imem_ack ? (id_stall && !flush) : !flush;
                end
                check("fetch_stall", fetch_stall, e_stall);
                check("imem_req", imem_req, e_req);
                check("imem_addr", imem_addr, e_addr);
                check("fetch_fault", fetch_fault, m_fault);
                check("id_pc", id_pc, m_pc);
                check("id_instr", id_instr, m_instr);
                check("id_valid", id_valid, m_valid);

                was_fault = m_fault;
                if (!m_started) begin
                    m_started = 1;
                end else if (m_fault) begin
                end else if (m_holding) begin
                    if (!flush && !id_stall) begin wr = 1; wr_instr = m_word; end
                    if (flush || !id_stall) m_holding = 0;
                end else if (m_dropping) begin
                    if (imem_ack) begin
                        m_dropping = 0; m_wait = 0;
                    end else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_fault = 1; m_dropping = 0; end
                    end
                end else if (pc[1:0] != 2'b00) begin
                    m_fault = 1;
                end else if (imem_ack) begin
                    m_wait = 0;
                    if (!flush && id_stall) begin m_holding = 1; m_word = imem_rdata; end
                    else if (!flush) begin wr = 1; wr_instr = imem_rdata; end
                end else if (flush) begin
                    m_dropping = 1; m_drop_addr = pc; m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) m_fault = 1;
                end

                if (flush && !was_fault) begin
                    m_valid = 0; m_instr = NOP;
                end else if (id_stall) begin
                end else if (wr) begin
                    m_pc = pc; m_instr = wr_instr; m_valid = 1;
                end else begin
                    m_valid = 0; m_instr = NOP;
                end
                prev_flush  = flush;
                prev_target = target;
                prev_stall  = e_stall;
            end
        end
    end

    initial begin
        // Same-cycle ack streaming
        mem_lat = 0;
        rst_cycle();
        tick(0); #4;
        check("rst_id_pc", id_pc, 32'h0100_0000);
        check("rst_id_instr", id_instr, 32'h0000_0013);
        check("rst_id_valid", id_valid, 1'b0);
        check("idle_stall", fetch_stall, 1'b1);
        check("idle_req", imem_req, 1'b0);
        tick(0); #4;
        check("a_stall", fetch_stall, 1'b0);
        check("a_addr", imem_addr, 32'h0100_0000);
        tick(0); #4;
        check("a_id_pc0", id_pc, 32'h0100_0000);
        check("a_valid", id_valid, 1'b1);
        tick(0); #4;
        check("a_id_pc1", id_pc, 32'h0100_0004);

        // Three-cycle latency
        mem_lat = 3;
        rst_cycle();
        repeat (4) tick(0);
        #4;
        check("b_addr", imem_addr, 32'h0100_0000);
        check("b_stall", fetch_stall, 1'b1);
        check("b_bubble", id_valid, 1'b0);
        tick(0);
        tick(0); #4;
        check("b_valid", id_valid, 1'b1);
        check("b_id_pc", id_pc, 32'h0100_0000);

        // Decode stall while ack arrives
        mem_lat = 0;
        rst_cycle();
        tick(0);
        drv_stall = 1;
        tick(0); #4;
        check("c_hold_stall", fetch_stall, 1'b1);
        repeat (3) tick(0);
        #4;
        check("c_hold_valid", id_valid, 1'b0);
        check("c_hold_req", imem_req, 1'b0);
        drv_stall = 0;
        tick(0); #4;
        check("c_release_stall", fetch_stall, 1'b0);
        tick(0); #4;
        check("c_valid", id_valid, 1'b1);
        check("c_id_pc", id_pc, 32'h0100_0000);
        check("c_id_instr", id_instr, word(32'h0100_0000));

        // Flush+ack in REQ, then flush during an outstanding request
        mem_lat = 0;
        rst_cycle();
        tick(0);
        drv_flush = 1; drv_target = 32'h0100_0010;
        tick(0); #4;
        check("d_flushack_stall", fetch_stall, 1'b0);
        drv_flush = 0; mem_lat = 3;
        tick(0); #4;
        check("d_flushack_bubble", id_valid, 1'b0);
        check("d_addr0", imem_addr, 32'h0100_0010);
        drv_flush = 1; drv_target = 32'h0100_0100;
        tick(0); #4;
        check("d_flush_stall", fetch_stall, 1'b0);
        drv_flush = 0;
        tick(0); #4;
        check("d_drop_addr", imem_addr, 32'h0100_0010);
        check("d_drop_stall", fetch_stall, 1'b1);
        tick(0); #4;
        check("d_drop_bubble", id_valid, 1'b0);
        mem_lat = 0;
        tick(0); #4;
        check("d_new_addr", imem_addr, 32'h0100_0100);
        tick(0); #4;
        check("d_id_pc", id_pc, 32'h0100_0100);

        // Timeout
        mem_lat = 100000;
        rst_cycle();
        req_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            tick(0); #4;
            if (fetch_fault === 1'b1) break;
            if (imem_req === 1'b1) req_cycles++;
        end
        check("e_req_cycles", req_cycles, 64);
        drv_flush = 1; drv_target = 32'h0100_0200;
        tick(0); #4;
        drv_flush = 0;
        check("e_fault", fetch_fault, 1'b1);
        check("e_req", imem_req, 1'b0);
        check("e_stall", fetch_stall, 1'b1);
        rst_cycle();
        tick(0); #4;
        check("e_cleared", fetch_fault, 1'b0);

        // Misaligned PC
        mem_lat = 0;
        rst_cycle();
        tick(0);
        drv_flush = 1; drv_target = 32'h0100_0002;
        tick(0);
        drv_flush = 0;
        tick(0); #4;
        check("f_no_req", imem_req, 1'b0);
        check("f_addr_zero", imem_addr, 32'h0);
        tick(0); #4;
        check("f_fault", fetch_fault, 1'b1);

        // Random traffic
        mem_lat = -1;
        rst_cycle();
        for (int i = 0; i < 3000; i++) begin
            drv_flush  = ($urandom_range(0, 9) == 0);
            drv_stall  = ($urandom_range(0, 3) == 0);
            drv_target = {16'h0100, 14'($urandom), 2'b00};
            tick($urandom_range(0, 499) == 0);
        end
        tick(0); #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of the PC counter in the five-stage RISC-V pipeline.
- Takes the current PC and issues a request to instruction memory using a req/ack handshake with variable latency.
- Writes the fetched instruction into the IF/ID pipeline register.
- Back-pressures the PC counter via fetch_stall, and handles decode stalls, branch flushes and fetch timeouts.

Parameters:
- RESET_PC, 32'h01000000, value presented on id_pc after reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).
- TIMEOUT_CYCLES, 64, number of cycles a request may wait for ack before a fault is raised.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- pc  in  32  current PC from the PC counter.
- fetch_stall  out  1  when high, the PC counter holds its value (gates its update).
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address; held stable while imem_req=1 and no ack.
- imem_ack  in  1  response valid; may arrive in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- id_stall  in  1  decode cannot accept a new instruction.
- flush  in  1  branch/jump taken; the PC counter loads the target this cycle.
- id_pc  out  32  IF/ID register: PC of the instruction.
- id_instr  out  32  IF/ID register: instruction.
- id_valid  out  1  IF/ID register: instruction valid.
- fetch_fault  out  1  sticky fault (misaligned PC or timeout).

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clock. Reset overrides everything, including any outstanding request, which is abandoned.
- Reset values: state=IDLE, id_valid=0, id_instr=NOP_INSTR, id_pc=RESET_PC, imem_req=0, fetch_stall=1, fetch_fault=0, wait counter=0, buffer=0.
- States: IDLE, REQ, HOLD, DROP, FAULT.
- IDLE:
  - fetch_stall=1, imem_req=0.
  - Unconditionally -> REQ on the next cycle.
- REQ:
  - imem_req=1, imem_addr=pc (combinational). PC is held stable by fetch_stall=1 unless a transfer or flush occurs.
  - pc[1:0]!=0: imem_req=0 -> FAULT.
  - ack & !flush & !id_stall: IF/ID <= {pc, rdata, valid=1}; fetch_stall=0; stay in REQ. Throughput is one instruction per cycle when ack is same-cycle.
  - ack & !flush & id_stall: buffer <= rdata; fetch_stall=1; -> HOLD.
  - ack & flush: discard rdata; fetch_stall=0; stay in REQ.
  - !ack & flush: latch req_addr <= pc; fetch_stall=0; -> DROP.
  - !ack & !flush: fetch_stall=1; wait counter increments.
- HOLD:
  - imem_req=0, fetch_stall=1.
  - flush: discard buffer; fetch_stall=0; -> REQ.
  - !id_stall: IF/ID <= {pc, buffer, 1}; fetch_stall=0; -> REQ.
- DROP:
  - imem_req=1, imem_addr=req_addr, fetch_stall=!flush.
  - On ack: discard rdata; -> REQ.
  - A repeated flush lets the PC counter take the new target; the state stays DROP until ack.
- FAULT:
  - imem_req=0, fetch_stall=1, fetch_fault=1.
  - Held until reset; flush is ignored.
- Timeout: the wait counter counts cycles with imem_req=1 & !ack in REQ/DROP and clears on ack or on a state change. When the count reaches TIMEOUT_CYCLES -> FAULT.
- IF/ID register, in priority order:
  1. flush -> {id_pc unchanged, NOP_INSTR, valid=0}.
  2. Else id_stall -> hold.
  3. Else written per the state rules above.
  4. Else bubble (valid=0, NOP_INSTR).
- flush has priority over id_stall and ack in every state except FAULT.
- imem_addr is 0 whenever imem_req=0.

Test Plan:
- Reset, then memory acks in the same cycle as req, pc stepping 0x01000000/04/08 -> id_pc/id_instr follow one cycle later with id_valid=1 every cycle; fetch_stall=1 only in the IDLE cycle.
- Memory ack latency of 3 cycles at pc=0x01000000 -> imem_addr held at 0x01000000 for 3 cycles with fetch_stall=1; id_valid=0 bubbles; instruction appears once.
- id_stall=1 for 4 cycles while ack arrives -> HOLD; IF/ID unchanged; on id_stall drop the buffered word is written with the correct pc and fetch_stall pulses low.
- Flush one cycle into a 3-cycle request at 0x01000010 (target 0x01000100) -> fetch_stall=0 that cycle; DROP keeps imem_addr=0x01000010 until ack; the stale data never reaches IF/ID; next request goes to 0x01000100.
- No ack for 64 cycles -> fetch_fault=1, imem_req=0, fetch_stall=1 held; reset clears to IDLE.
- pc=0x01000002 in REQ -> immediate FAULT, no request issued; flush and ack coincident in REQ -> IF/ID bubble, stays in REQ.
